// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequencing controller for a multicycle datapath. An instruction is taken
// in IDLE through an instr_valid/instr_ready handshake. The opcode and type
// are latched, decoded, and then stepped through EXEC / MEM / WB / DISP /
// DONE as the instruction class requires. All outputs are decoded from the
// registered state and the latched instruction. No input reaches an output
// combinationally.
//
// Ports
//   clk, rst_n       clock (rising edge); asynchronous active-low reset
//   instr_valid      opcode/instr_type are valid
//   instr_ready      accept strobe, high only in IDLE
//   opcode           operation code (OPCODE_W bits)
//   instr_type       00 ALU, 01 load/store, 11 display, 10 reserved
//   disp_ack         display consumed; only looked at in DISP
//   mem_read_en      memory read (load in MEM, 10111 in DISP)
//   mem_write_en     memory write (store in MEM)
//   reg_write_en     register file write, one cycle in WB
//   alu_imm          ALU B operand is the immediate (EXEC only)
//   display          display request, held through DISP
//   data_to_reg      write-back source: 00 none, 01 mem, 10 ALU, 11 imm
//   pc_inc           one-cycle pulse in DONE
//   busy             high in every state except IDLE
//   illegal          one-cycle pulse in DECODE for an undecodable instruction
module multicycle_control_unit #(
    parameter int OPCODE_W = 5,
    parameter int MEM_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          instr_type,
    input  logic                disp_ack,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                reg_write_en,
    output logic                alu_imm,
    output logic                display,
    output logic [1:0]          data_to_reg,
    output logic                pc_inc,
    output logic                busy,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DISP, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_ALU, C_CMP, C_LOAD, C_LDI, C_STORE, C_DISP
    } cls_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);
    localparam logic [4:0] OP_DISP_MEM = 5'b10111;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [1:0]          type_q, type_d;
    logic [3:0]          cnt_q, cnt_d;
    cls_t                cls;
    logic [4:0]          lo;

    // Instruction class from the latched opcode/type. Any set bit above bit 4
    // makes the instruction illegal regardless of type.
    function automatic cls_t classify(input logic [OPCODE_W-1:0] op,
                                      input logic [1:0] ty);
        cls_t c;
        c = C_ILL;
        if ((op >> 5) == '0) begin
            case (ty)
                2'b00: begin
                    case (op[4:0])
                        5'b00011, 5'b00100, 5'b00101, 5'b00110,
                        5'b01000, 5'b01001, 5'b01010, 5'b01011,
                        5'b01100, 5'b01101, 5'b01110, 5'b01111: c = C_ALU;
                        5'b11001, 5'b00111, 5'b10000, 5'b10001,
                        5'b10010, 5'b10011:                      c = C_CMP;
                        default:                                 c = C_ILL;
                    endcase
                end
                2'b01: begin
                    case (op[4:0])
                        5'b00000: c = C_LOAD;
                        5'b00001: c = C_LDI;
                        5'b00010: c = C_STORE;
                        default:  c = C_ILL;
                    endcase
                end
                2'b11: begin
                    case (op[4:0])
                        5'b10101, 5'b10110, 5'b10111, 5'b11000: c = C_DISP;
                        default:                                c = C_ILL;
                    endcase
                end
                default: c = C_ILL;
            endcase
        end
        return c;
    endfunction

    function automatic logic uses_imm(input logic [4:0] op);
        case (op)
            5'b00100, 5'b00110, 5'b00111,
            5'b01111, 5'b10001, 5'b10011: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    assign lo  = op_q[4:0];
    assign cls = classify(op_q, type_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            type_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    type_d  = instr_type;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_ALU, C_CMP, C_LOAD, C_STORE: state_d = S_EXEC;
                    C_LDI:                         state_d = S_WB;
                    C_DISP:                        state_d = S_DISP;
                    default:                       state_d = S_IDLE;
                endcase
            end
            S_EXEC: begin
                // Loads and stores spend EXEC on address generation.
                case (cls)
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                        cnt_d   = CNT_LOAD;
                    end
                    C_ALU:   state_d = S_WB;
                    default: state_d = S_DONE;
                endcase
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = (cls == C_LOAD) ? S_WB : S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB:   state_d = S_DONE;
            S_DISP: if (disp_ack) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready  = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        illegal      = (state_q == S_DECODE) && (cls == C_ILL);
        alu_imm      = (state_q == S_EXEC) && ((cls == C_ALU) || (cls == C_CMP))
                       && uses_imm(lo);
        mem_read_en  = ((state_q == S_MEM) && (cls == C_LOAD))
                       || ((state_q == S_DISP) && (lo == OP_DISP_MEM));
        mem_write_en = (state_q == S_MEM) && (cls == C_STORE);
        reg_write_en = (state_q == S_WB);
        display      = (state_q == S_DISP);
        pc_inc       = (state_q == S_DONE);
        data_to_reg  = 2'b00;
        if (state_q == S_WB) begin
            case (cls)
                C_LOAD:  data_to_reg = 2'b01;
                C_LDI:   data_to_reg = 2'b11;
                default: data_to_reg = 2'b10;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int OW = 6;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [OW-1:0] opcode;
    logic [1:0]    instr_type;
    logic          disp_ack;
    logic          mem_read_en, mem_write_en, reg_write_en, alu_imm, display;
    logic [1:0]    data_to_reg;
    logic          pc_inc, busy, illegal;

    multicycle_control_unit #(.OPCODE_W(OW), .MEM_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .instr_type(instr_type),
        .disp_ack(disp_ack), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .reg_write_en(reg_write_en),
        .alu_imm(alu_imm), .display(display), .data_to_reg(data_to_reg),
        .pc_inc(pc_inc), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected per-instruction profile: latency handshake->end pulse, and the
    // number of cycles each enable was seen high over the instruction.
    typedef struct packed {
        int id; int lat; int rd; int wr; int rw; int dtr; int imm; int disp; int ill;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, id, act, expv, $time);
    endtask

    function automatic exp_t mk(int id, int lat, int rd, int wr, int rw, int dtr,
                                int imm, int disp, int ill);
        exp_t e;
        e.id = id; e.lat = lat; e.rd = rd; e.wr = wr; e.rw = rw;
        e.dtr = dtr; e.imm = imm; e.disp = disp; e.ill = ill;
        return e;
    endfunction

    // Monitor: builds the observed profile of each accepted instruction and
    // compares it against the head of the queue when pc_inc or illegal fires.
    bit   active = 0, pend = 0;
    int   hs, a_rd, a_wr, a_rw, a_dtr, a_imm, a_disp, a_ill;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            pend   = 0;
        end else begin
            if (pend) begin
                chk("ready_after_end", e.id, int'(instr_ready), 1);
                pend = 0;
            end
            if (active) begin
                a_rd   += int'(mem_read_en);
                a_wr   += int'(mem_write_en);
                a_rw   += int'(reg_write_en);
                a_imm  += int'(alu_imm);
                a_disp += int'(display);
                if (reg_write_en) a_dtr = int'(data_to_reg);
                if (pc_inc || illegal) begin
                    a_ill = int'(illegal);
                    if (q.size() == 0) begin
                        chk("unexpected_end", -1, 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", e.id, cyc - hs, e.lat);
                        chk("mem_read_cycles", e.id, a_rd, e.rd);
                        chk("mem_write_cycles", e.id, a_wr, e.wr);
                        chk("reg_write_cycles", e.id, a_rw, e.rw);
                        chk("data_to_reg", e.id, a_dtr, e.dtr);
                        chk("alu_imm_cycles", e.id, a_imm, e.imm);
                        chk("display_cycles", e.id, a_disp, e.disp);
                        chk("illegal", e.id, a_ill, e.ill);
                        pend = 1;
                    end
                    active = 0;
                end
            end else begin
                chk("idle_quiet", -1,
                    int'({pc_inc, illegal, reg_write_en, mem_read_en, mem_write_en,
                          display, alu_imm, busy, data_to_reg}), 0);
            end
            if (instr_valid && instr_ready) begin
                if (active) chk("accept_while_busy", -1, 1, 0);
                active = 1; hs = cyc;
                a_rd = 0; a_wr = 0; a_rw = 0; a_dtr = 0; a_imm = 0; a_disp = 0; a_ill = 0;
            end
        end
    end

    // Drives one instruction; called just after a rising edge. Returns just
    // after the handshake edge. hold keeps instr_valid high afterwards.
    task automatic issue(input logic [OW-1:0] op, input logic [1:0] ty,
                         input exp_t ex, input bit push, input bit hold);
        int n = 0;
        instr_valid = 1'b1; opcode = op; instr_type = ty;
        if (push) q.push_back(ex);
        while (!instr_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("accept_timeout", ex.id, 1, 0);
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!instr_ready && n < 200);
        if (n >= 200) chk("idle_timeout", id, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; instr_type = 2'b00; disp_ack = 1'b0;
        #1;
        chk("reset_ready", 0, int'(instr_ready), 1);
        chk("reset_outputs", 0,
            int'({pc_inc, illegal, reg_write_en, mem_read_en, mem_write_en,
                  display, alu_imm, busy, data_to_reg}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // id  lat rd wr rw dtr imm disp ill
        issue(6'b000011, 2'b00, mk(1, 4, 0, 0, 1, 2, 0, 0, 0), 1, 0); wait_idle(1);
        issue(6'b000100, 2'b00, mk(2, 4, 0, 0, 1, 2, 1, 0, 0), 1, 0); wait_idle(2);
        issue(6'b011001, 2'b00, mk(3, 3, 0, 0, 0, 0, 0, 0, 0), 1, 0); wait_idle(3);
        issue(6'b000000, 2'b01, mk(4, 4+ML, ML, 0, 1, 1, 0, 0, 0), 1, 0); wait_idle(4);
        issue(6'b000001, 2'b01, mk(5, 3, 0, 0, 1, 3, 0, 0, 0), 1, 0); wait_idle(5);
        issue(6'b000010, 2'b01, mk(6, 3+ML, 0, ML, 0, 0, 0, 0, 0), 1, 0); wait_idle(6);
        issue(6'b000011, 2'b10, mk(7, 1, 0, 0, 0, 0, 0, 0, 1), 1, 0); wait_idle(7);
        issue(6'b100011, 2'b00, mk(8, 1, 0, 0, 0, 0, 0, 0, 1), 1, 0); wait_idle(8);
        issue(6'b010100, 2'b00, mk(9, 1, 0, 0, 0, 0, 0, 0, 1), 1, 0); wait_idle(9);
        issue(6'b000011, 2'b11, mk(10, 1, 0, 0, 0, 0, 0, 0, 1), 1, 0); wait_idle(10);

        // Display from memory: ack withheld for the first 5 DISP cycles.
        issue(6'b010111, 2'b11, mk(11, 8, 6, 0, 0, 0, 0, 6, 0), 1, 0);
        repeat (6) begin @(posedge clk); #1; end
        disp_ack = 1'b1;
        @(posedge clk); #1;
        disp_ack = 1'b0;
        wait_idle(11);

        // Ack already high (ignored in IDLE/DECODE), DISP lasts one cycle.
        disp_ack = 1'b1;
        issue(6'b010101, 2'b11, mk(12, 3, 0, 0, 0, 0, 0, 1, 0), 1, 0);
        wait_idle(12);
        disp_ack = 1'b0;

        // Back-to-back: store, then compare-immediate with valid held high.
        issue(6'b000010, 2'b01, mk(13, 3+ML, 0, ML, 0, 0, 0, 0, 0), 1, 1);
        issue(6'b010011, 2'b00, mk(14, 3, 0, 0, 0, 0, 1, 0, 0), 1, 0);
        wait_idle(14);

        // Reset in the second MEM cycle of a store.
        issue(6'b000010, 2'b01, mk(15, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("store_mem_wr_before_reset", 15, int'(mem_write_en), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_drop_mem_wr", 15, int'(mem_write_en), 0);
        chk("async_ready", 15, int'(instr_ready), 1);
        chk("async_busy", 15, int'(busy), 0);
        @(posedge clk); #1;
        chk("reset_hold_pc_inc", 15, int'(pc_inc), 0);
        rst_n = 1'b1;
        issue(6'b001000, 2'b00, mk(16, 4, 0, 0, 1, 2, 0, 0, 0), 1, 0);
        wait_idle(16);

        repeat (3) @(posedge clk);
        #1 chk("queue_drained", 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The parameter OPCODE_W SHALL default to 5 and set the opcode width; legal range is 5..8.
REQ-002 The parameter MEM_LAT SHALL default to 2 and set the data-memory access cycles; legal range is 1..15.
REQ-003 The port clk SHALL be an input of width 1; it is the single clock, and all state changes on its rising edge.
REQ-004 The port rst_n SHALL be an input of width 1; reset is asynchronous and active-low.
REQ-005 The port instr_valid SHALL be an input of width 1; it marks opcode and instr_type as valid.
REQ-006 The port instr_ready SHALL be an output of width 1; it is the instruction accept strobe.
REQ-007 The port opcode SHALL be an input of width OPCODE_W carrying the operation code.
REQ-008 The port instr_type SHALL be an input of width 2: 00 = ALU, 01 = load/store, 11 = display, 10 = reserved.
REQ-009 The port disp_ack SHALL be an input of width 1; it is the display-consumed acknowledge.
REQ-010 The outputs mem_read_en, mem_write_en, reg_write_en, alu_imm and display SHALL each be 1 bit wide.
REQ-011 The output data_to_reg SHALL be 2 bits wide: 00 none, 01 memory, 10 ALU, 11 immediate.
REQ-012 The outputs pc_inc, busy and illegal SHALL each be 1 bit wide; pc_inc and illegal are 1-cycle pulses.

Function
REQ-013 The block SHALL use the states IDLE, DECODE, EXEC, MEM, WB, DISP and DONE.
REQ-014 The block SHALL assert instr_ready only in IDLE.
- Handshake: instr_valid && instr_ready.
- On handshake, latch opcode and instr_type, then go to DECODE.
- Inputs are ignored in every other state.
REQ-015 In DECODE, an instruction SHALL be illegal when any of the following holds: instr_type == 10; opcode[OPCODE_W-1:5] is non-zero; or opcode[4:0] is not in the table below for its type.
- Illegal: pulse illegal for 1 cycle and return to IDLE.
- No enable is asserted and pc_inc does not pulse.
REQ-016 Load/store opcodes SHALL be routed as follows:
- 00000 load: MEM then WB, data_to_reg = 01.
- 00001 load immediate: WB, data_to_reg = 11.
- 00010 store: MEM then DONE.
REQ-017 ALU write-back opcodes SHALL go EXEC then WB with data_to_reg = 10: 00011, 00100, 00101, 00110, 01000, 01001, 01010, 01011, 01100, 01101, 01110, 01111.
REQ-018 Compare opcodes SHALL go EXEC then DONE with reg_write_en = 0: 11001, 00111, 10000, 10001, 10010, 10011.
REQ-019 alu_imm SHALL be 1 during EXEC only for opcodes 00100, 00110, 00111, 01111, 10001 and 10011; it is 0 otherwise.
REQ-020 In MEM, the block SHALL hold mem_read_en (load) or mem_write_en (store) high for exactly MEM_LAT consecutive cycles, using a down-counter loaded with MEM_LAT-1 on entry and exiting on zero.
REQ-021 In WB, the block SHALL assert reg_write_en for exactly 1 cycle with data_to_reg valid, then go to DONE.
REQ-022 Display opcodes 10101, 10110, 10111 and 11000 SHALL go to DISP.
- DISP holds display = 1 until disp_ack is sampled high, then goes to DONE.
- For 10111 only, mem_read_en = 1 throughout DISP.
- There is no timeout.
REQ-023 In DONE, the block SHALL pulse pc_inc for 1 cycle and return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 All enables SHALL be 0 in states other than those specified above.
- data_to_reg = 00 outside WB.
- Outputs decode from the registered state and latched instruction only, with no combinational path from inputs.
REQ-026 disp_ack SHALL be ignored outside DISP; an ack asserted on the DISP entry cycle completes DISP in 1 cycle.
REQ-027 Instruction latency from handshake to pc_inc SHALL be:
- ALU write-back: 4.
- Compare: 3.
- Load: 4+MEM_LAT.
- Load immediate: 3.
- Store: 3+MEM_LAT.
- Display: 3 + wait cycles.

Reset
REQ-028 While rst_n = 0, the state SHALL be IDLE, the latch and counter SHALL be cleared, every output except instr_ready SHALL be 0, and instr_ready SHALL be 1.
REQ-029 Reset asserted mid-instruction (including MEM and DISP) SHALL abort it immediately, with no further enable or pc_inc.

Verification
REQ-030 Add (type 00, opcode 00011, MEM_LAT = 2) -> reg_write_en and data_to_reg = 10 for 1 cycle at cycle 3; pc_inc at cycle 4.
REQ-031 Load (type 01, opcode 00000, MEM_LAT = 3) -> mem_read_en for exactly 3 cycles, then reg_write_en with data_to_reg = 01; pc_inc at cycle 7.
REQ-032 Display memory (type 11, opcode 10111), disp_ack withheld 5 cycles -> display and mem_read_en high until the ack; pc_inc 1 cycle later.
REQ-033 Illegal inputs (type 10, any opcode; OPCODE_W = 6 with opcode 100011) -> illegal pulse, no enables, no pc_inc, instr_ready back high at cycle 2.
REQ-034 rst_n low during the second MEM cycle of a store -> mem_write_en drops asynchronously, instr_ready = 1, and a new instruction is accepted right after release.
REQ-035 instr_valid held high back-to-back (store then equal-immediate 10011) -> second accepted only in IDLE; alu_imm = 1 only in its EXEC cycle, and reg_write_en never asserted.
